// File: rtl/ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_fifo
// Description : PS/2 device-to-host receiver feeding a byte FIFO. Samples the
//               raw keyboard clock/data lines, deframes 11-bit frames
//               (start, 8 data bits LSB first, odd parity, stop), checks them
//               and queues good bytes. The consumer drains the queue with a
//               ready / nextdata_n handshake.
// Ports       : clk        - system clock
//               clrn       - asynchronous active-low reset
//               ps2_clk    - raw keyboard clock (asynchronous)
//               ps2_data   - raw keyboard data (asynchronous)
//               nextdata_n - consumer advance request, pops on falling edge
//               data       - byte at FIFO head, valid while ready = 1
//               ready      - FIFO non-empty
//               overflow   - sticky, a good byte was dropped (FIFO full)
//               frame_err  - one-cycle pulse, a completed frame was bad
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [3:0]    CNT_STOP = 4'd10;

  // Synchronizer chains: bit 0 is the newest sample, bit 2 the oldest.
  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic          fall;
  logic          bit_in;

  // Deframer state
  logic [3:0]    cnt;
  logic [9:0]    buffer;
  logic [TW-1:0] tcnt;

  // FIFO state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic          nd_q;

  logic          frame_done;
  logic          frame_good;
  logic          full;
  logic          push;
  logic          pop;

  // --------------------------------------------------------------------------
  // Input synchronization; lines idle high, so the chains reset to 1 and no
  // spurious falling edge appears when reset is released.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  // The keyboard holds data stable around its clock fall, so the oldest
  // data stage is well settled when fall is seen.
  assign bit_in = data_sync[2];

  // --------------------------------------------------------------------------
  // Frame check: evaluated in the cycle that samples the stop bit.
  // --------------------------------------------------------------------------
  assign frame_done = fall & (cnt == CNT_STOP);
  assign frame_good = ~buffer[0] & bit_in & (^buffer[9:1]);

  // Full is judged on the pre-pop pointers, so a same-cycle pop never makes
  // room for the incoming byte.
  assign full = ((w_ptr + PTR_ONE) == r_ptr);
  assign push = frame_done & frame_good & ~full;
  assign pop  = nd_q & ~nextdata_n & ready;

  // --------------------------------------------------------------------------
  // Deframer and inter-bit timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      buffer <= '0;
      tcnt   <= '0;
    end else if (fall) begin
      tcnt <= '0;
      if (cnt == CNT_STOP) begin
        cnt <= '0;
      end else begin
        buffer[cnt] <= bit_in;
        cnt         <= cnt + 4'd1;
      end
    end else if (cnt == 4'd0) begin
      tcnt <= '0;
    end else if (tcnt == TO_LAST) begin
      // Abandon a stalled partial frame silently and wait for a new start.
      cnt  <= '0;
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frame_done & ~frame_good;
      if (frame_done & frame_good & full) begin
        overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. The array is cleared on reset so data reads 0x00 the
  // instant clrn asserts, without waiting for a clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[w_ptr] <= buffer[8:1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
      nd_q  <= 1'b1;
    end else begin
      nd_q <= nextdata_n;
      if (push) begin
        w_ptr <= w_ptr + PTR_ONE;
      end
      if (pop) begin
        r_ptr <= r_ptr + PTR_ONE;
      end
    end
  end

  assign ready = (w_ptr != r_ptr);
  assign data  = mem[r_ptr];

endmodule
`default_nettype wire
